// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end owning the PC, the imem request channel and the held instruction.
// Define FETCH_UNIT_PERF_EN to add the perf_retired / perf_stall counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  input  logic        retire,
  input  logic [31:0] next_pc,
  output logic        fetch_fault
`ifdef FETCH_UNIT_PERF_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_stall
`endif
);

  // state | meaning
  // IDLE  | first cycle after reset, no request yet
  // REQ   | request presented, held stable until accepted
  // WAIT  | request accepted, waiting for the response word
  // HOLD  | instruction held for decode until retire
  // FAULT | misaligned PC loaded, frozen until reset
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        capture;
  logic        take_retire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    take_retire = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (imem_req_ready) state_nxt = WAIT;
      WAIT: begin
        if (imem_resp_valid) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (retire) begin
          take_retire = 1'b1;
          state_nxt   = (next_pc[1:0] != 2'b00) ? FAULT : REQ;
        end
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  // On a fault the misaligned target is still loaded so it shows on imem_req_addr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      instr      <= 32'h0;
      instr_addr <= RESET_PC;
    end else begin
      if (take_retire) pc <= next_pc;
      if (capture) begin
        instr      <= imem_resp_data;
        instr_addr <= pc;
      end
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign instr_valid    = (state == HOLD);
  assign fetch_fault    = (state == FAULT);

`ifdef FETCH_UNIT_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_retired <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (take_retire) perf_retired <= perf_retired + 32'd1;
      if ((state == REQ && !imem_req_ready) || state == WAIT)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, multi-cycle corner sequences and a randomized run against a reference model.
// Honours FETCH_UNIT_PERF_EN to also check the perf counters.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        retire;
  logic [31:0] next_pc;
  logic        fetch_fault;
`ifdef FETCH_UNIT_PERF_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_stall;
`endif

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_addr     (instr_addr),
    .retire         (retire),
    .next_pc        (next_pc),
    .fetch_fault    (fetch_fault)
`ifdef FETCH_UNIT_PERF_EN
    ,
    .perf_retired   (perf_retired),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic rv, input logic [31:0] addr, input logic iv,
                            input logic [31:0] ins, input logic [31:0] iaddr, input logic flt);
    chk({tag, ".req_valid"},   32'(imem_req_valid), 32'(rv));
    chk({tag, ".req_addr"},    imem_req_addr,       addr);
    chk({tag, ".instr_valid"}, 32'(instr_valid),    32'(iv));
    chk({tag, ".instr"},       instr,               ins);
    chk({tag, ".instr_addr"},  instr_addr,          iaddr);
    chk({tag, ".fetch_fault"}, 32'(fetch_fault),    32'(flt));
  endtask

  task automatic drv(input logic rdy, input logic rsv, input logic [31:0] rsd, input logic ret,
                     input logic [31:0] npc);
    imem_req_ready  = rdy;
    imem_resp_valid = rsv;
    imem_resp_data  = rsd;
    retire          = ret;
    next_pc         = npc;
  endtask

  // Returns at a falling edge with reset just released: the current cycle is cycle 0.
  task automatic restart();
    @(negedge clk);
    reset_n = 1'b0;
    drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  typedef struct {
    logic        rdy;
    logic        rsv;
    logic [31:0] rsd;
    logic        ret;
    logic [31:0] npc;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_iaddr;
  } vec_t;

  function automatic vec_t mkv(input logic rdy, input logic rsv, input logic [31:0] rsd, input logic ret,
                               input logic [31:0] npc, input logic e_rv, input logic [31:0] e_addr,
                               input logic e_iv, input logic [31:0] e_instr, input logic [31:0] e_iaddr);
    vec_t v;
    v.rdy = rdy; v.rsv = rsv; v.rsd = rsd; v.ret = ret; v.npc = npc;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_instr = e_instr; v.e_iaddr = e_iaddr;
    return v;
  endfunction

  // reference model for the randomized run
  logic        m_start, m_issue, m_fly, m_hold, m_flt;
  logic [31:0] m_pc, m_instr, m_iaddr, m_ret, m_stall;
  int          flt_cycles;

  task automatic model_reset();
    m_start = 1'b1; m_issue = 1'b0; m_fly = 1'b0; m_hold = 1'b0; m_flt = 1'b0;
    m_pc = RPC; m_instr = 32'h0; m_iaddr = RPC; m_ret = 32'h0; m_stall = 32'h0;
    flt_cycles = 0;
  endtask

  vec_t vecs[17];

  initial begin
    logic        pend, in_reset, rdy, rsv, ret;
    logic [31:0] rsd, npc, acc_addr, tmp;
    int          lat, nreq, r;

    reset_n = 1'b0;
    drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    vecs[0]  = mkv(1, 0, 32'h0,         0, 32'h0,   0, 32'h100, 0, 32'h0,         32'h100);
    vecs[1]  = mkv(1, 0, 32'h0,         0, 32'h0,   1, 32'h100, 0, 32'h0,         32'h100);
    vecs[2]  = mkv(0, 1, 32'h0000_0013, 0, 32'h0,   0, 32'h100, 0, 32'h0,         32'h100);
    vecs[3]  = mkv(1, 0, 32'h0,         1, 32'h104, 0, 32'h100, 1, 32'h0000_0013, 32'h100);
    vecs[4]  = mkv(1, 0, 32'h0,         0, 32'h0,   1, 32'h104, 0, 32'h0000_0013, 32'h100);
    vecs[5]  = mkv(0, 1, 32'h0000_0AAA, 0, 32'h0,   0, 32'h104, 0, 32'h0000_0013, 32'h100);
    vecs[6]  = mkv(1, 0, 32'h0,         1, 32'h108, 0, 32'h104, 1, 32'h0000_0AAA, 32'h104);
    vecs[7]  = mkv(1, 0, 32'h0,         0, 32'h0,   1, 32'h108, 0, 32'h0000_0AAA, 32'h104);
    vecs[8]  = mkv(0, 1, 32'h0000_0BBB, 0, 32'h0,   0, 32'h108, 0, 32'h0000_0AAA, 32'h104);
    vecs[9]  = mkv(0, 0, 32'h0,         1, 32'h200, 0, 32'h108, 1, 32'h0000_0BBB, 32'h108);
    vecs[10] = mkv(0, 1, 32'hDEAD_BEEF, 0, 32'h0,   1, 32'h200, 0, 32'h0000_0BBB, 32'h108);
    vecs[11] = mkv(1, 0, 32'h0,         0, 32'h0,   1, 32'h200, 0, 32'h0000_0BBB, 32'h108);
    vecs[12] = mkv(0, 0, 32'h0,         0, 32'h0,   0, 32'h200, 0, 32'h0000_0BBB, 32'h108);
    vecs[13] = mkv(0, 1, 32'h0000_0CCC, 0, 32'h0,   0, 32'h200, 0, 32'h0000_0BBB, 32'h108);
    vecs[14] = mkv(0, 0, 32'h0,         0, 32'h0,   0, 32'h200, 1, 32'h0000_0CCC, 32'h200);
    vecs[15] = mkv(0, 0, 32'h0,         1, 32'h204, 0, 32'h200, 1, 32'h0000_0CCC, 32'h200);
    vecs[16] = mkv(1, 0, 32'h0,         0, 32'h0,   1, 32'h204, 0, 32'h0000_0CCC, 32'h200);

    // reset values while reset is held
    #12;
    check_outs("reset", 1'b0, RPC, 1'b0, 32'h0, RPC, 1'b0);
`ifdef FETCH_UNIT_PERF_EN
    chk("reset.perf_retired", perf_retired, 32'h0);
    chk("reset.perf_stall",   perf_stall,   32'h0);
`endif

    // directed table: sequential run, taken branch, stray response in REQ
    restart();
    for (int i = 0; i < 17; i++) begin
      check_outs($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_iv,
                 vecs[i].e_instr, vecs[i].e_iaddr, 1'b0);
      drv(vecs[i].rdy, vecs[i].rsv, vecs[i].rsd, vecs[i].ret, vecs[i].npc);
      @(negedge clk);
    end

    // backpressure: 5 cycles of ready=0
    restart();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d.req_valid", k), 32'(imem_req_valid), 32'h1);
      chk($sformatf("bp%0d.req_addr", k),  imem_req_addr,       RPC);
    end
    @(negedge clk);
    chk("bp6.req_valid", 32'(imem_req_valid), 32'h1);
    drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("bp7.req_valid", 32'(imem_req_valid), 32'h0);
    drv(1'b0, 1'b1, 32'h0000_0055, 1'b0, 32'h0);
    @(negedge clk);
    check_outs("bp8", 1'b0, RPC, 1'b1, 32'h0000_0055, RPC, 1'b0);
`ifdef FETCH_UNIT_PERF_EN
    chk("bp8.perf_stall", perf_stall, 32'd6);
`endif

    // misaligned target faults, stays quiet, async reset clears it
    restart();
    drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    drv(1'b0, 1'b1, 32'h0000_0077, 1'b0, 32'h0);
    @(negedge clk);
    chk("mis3.instr_valid", 32'(instr_valid), 32'h1);
    drv(1'b1, 1'b0, 32'h0, 1'b1, 32'h202);
    @(negedge clk);
    check_outs("mis4", 1'b0, 32'h202, 1'b0, 32'h0000_0077, RPC, 1'b1);
`ifdef FETCH_UNIT_PERF_EN
    chk("mis4.perf_retired", perf_retired, 32'd1);
`endif
    nreq = 0;
    for (int k = 0; k < 20; k++) begin
      drv(1'b1, k[0], 32'hFFFF_0000, 1'b1, 32'h300);
      @(negedge clk);
      if (imem_req_valid) nreq++;
    end
    chk("mis.requests_after_fault", 32'(nreq), 32'h0);
    check_outs("mis24", 1'b0, 32'h202, 1'b0, 32'h0000_0077, RPC, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_outs("mis_async_rst", 1'b0, RPC, 1'b0, 32'h0, RPC, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // reset asserted while in WAIT, then restart from RESET_PC
    restart();
    drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    drv(1'b0, 1'b1, 32'h0000_0099, 1'b0, 32'h0);
    @(negedge clk);
    drv(1'b0, 1'b0, 32'h0, 1'b1, 32'h400);
    @(negedge clk);
    drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("wr.pre_req_addr", imem_req_addr, 32'h400);
    @(negedge clk);
    chk("wr.in_wait", 32'(imem_req_valid), 32'h0);
    #2 reset_n = 1'b0;
    #1 check_outs("wr_async_rst", 1'b0, RPC, 1'b0, 32'h0, RPC, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    drv(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    check_outs("wr_restart", 1'b1, RPC, 1'b0, 32'h0, RPC, 1'b0);

    // randomized run against the reference model
    @(negedge clk);
    reset_n = 1'b0;
    drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    model_reset();
    in_reset = 1'b1;
    pend = 1'b0;
    lat = 0;
    acc_addr = 32'h0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check_outs("rand", m_issue, m_pc, m_hold, m_instr, m_iaddr, m_flt);
`ifdef FETCH_UNIT_PERF_EN
      chk("rand.perf_retired", perf_retired, m_ret);
      chk("rand.perf_stall",   perf_stall,   m_stall);
`endif
      if (in_reset) begin
        reset_n = 1'b1;
        in_reset = 1'b0;
      end else if (m_flt && flt_cycles >= 4) begin
        reset_n = 1'b0;
        in_reset = 1'b1;
        pend = 1'b0;
        drv(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        model_reset();
        continue;
      end
      rdy = (($urandom % 8) < 5);
      if (pend) begin
        if (lat == 0) begin
          rsv = 1'b1;
          rsd = mem_word(acc_addr);
          pend = 1'b0;
        end else begin
          lat--;
          rsv = 1'b0;
          rsd = $urandom;
        end
      end else begin
        rsv = (($urandom % 8) == 0);
        rsd = $urandom;
      end
      if (imem_req_valid && rdy) begin
        pend = 1'b1;
        lat = $urandom_range(2, 0);
        acc_addr = imem_req_addr;
      end
      ret = $urandom_range(1, 0) == 1;
      r = $urandom_range(31, 0);
      tmp = $urandom;
      if (r < 3)       npc = tmp & 32'hFFFF_FFFC;
      else if (r == 3) npc = tmp | 32'h1;
      else if (r == 4) npc = 32'hFFFF_FFFC;
      else             npc = m_iaddr + 32'd4;
      drv(rdy, rsv, rsd, ret, npc);

      if (m_flt) flt_cycles++;
      else if (m_start) begin
        m_start = 1'b0;
        m_issue = 1'b1;
      end else if (m_issue) begin
        if (!rdy) m_stall++;
        else begin
          m_issue = 1'b0;
          m_fly = 1'b1;
        end
      end else if (m_fly) begin
        m_stall++;
        if (rsv) begin
          m_instr = rsd;
          m_iaddr = m_pc;
          m_fly = 1'b0;
          m_hold = 1'b1;
        end
      end else if (m_hold && ret) begin
        m_ret++;
        m_pc = npc;
        m_hold = 1'b0;
        if (npc[1:0] != 2'b00) m_flt = 1'b1;
        else m_issue = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
